// File: rtl/ram_loader_if.sv
// Control, stream and RAM-port bundle for the ram_loader bulk-transfer engine.
// The loader is the slave: it takes commands and streams, and drives the RAM port.
interface ram_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              start_load;
  logic              start_dump;
  logic              abort;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic              busy;
  logic              cpu_hold;
  logic              done;

  modport master (
    output start_load, start_dump, abort, in_data, in_valid, out_ready, ram_dout,
    input  in_ready, out_data, out_valid, ram_en, ram_we, ram_addr, ram_din,
           busy, cpu_hold, done
  );

  modport slave (
    input  start_load, start_dump, abort, in_data, in_valid, out_ready, ram_dout,
    output in_ready, out_data, out_valid, ram_en, ram_we, ram_addr, ram_din,
           busy, cpu_hold, done
  );
endinterface

// File: rtl/ram_loader.sv
// Loads a byte stream into the 16x8 data RAM or dumps the RAM out as a stream,
// holding the CPU while it owns the RAM port.
module ram_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic        clk,
  input  logic        areset,
  ram_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, DUMP_RD, DUMP_OUT} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              done_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state  <= IDLE;
      ptr    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state != IDLE && bus.abort) begin
        state <= IDLE;
        ptr   <= '0;
      end else begin
        case (state)
          IDLE: if (!bus.abort) begin
            if (bus.start_load) begin
              state <= LOAD;
              ptr   <= '0;
            end else if (bus.start_dump) begin
              state <= DUMP_RD;
              ptr   <= '0;
            end
          end
          LOAD: if (bus.in_valid) begin
            if (ptr == LAST) begin
              state  <= IDLE;
              ptr    <= '0;
              done_q <= 1'b1;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
          DUMP_RD: state <= DUMP_OUT;
          DUMP_OUT: if (bus.out_ready) begin
            if (ptr == LAST) begin
              state  <= IDLE;
              ptr    <= '0;
              done_q <= 1'b1;
            end else begin
              ptr   <= ptr + 1'b1;
              state <= DUMP_RD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Handshakes and RAM strobes are combinational so a load runs at one word per cycle;
  // abort kills whatever transfer would have happened this cycle.
  assign bus.in_ready  = (state == LOAD) && !bus.abort;
  assign bus.ram_we    = (state == LOAD) && bus.in_valid && !bus.abort;
  assign bus.ram_en    = !bus.abort && (((state == LOAD) && bus.in_valid) || (state == DUMP_RD));
  assign bus.ram_addr  = (state == IDLE) ? '0 : ptr;
  assign bus.ram_din   = (state == LOAD) ? bus.in_data : '0;
  assign bus.out_valid = (state == DUMP_OUT) && !bus.abort;
  // ram_en is low in DUMP_OUT, so the RAM keeps dout stable through consumer stalls.
  assign bus.out_data  = (state == DUMP_OUT) ? bus.ram_dout : '0;
  assign bus.busy      = (state != IDLE);
  assign bus.cpu_hold  = (state != IDLE);
  assign bus.done      = done_q;
endmodule

// File: tb/tb_ram_loader.sv
// Randomized bench for ram_loader: a reference image and expected-event queues are
// filled by the stimulus; negedge monitors pop and compare whenever the DUT acts.
module tb_ram_loader;
  logic clk;
  logic areset;
  int   cyc;
  int   nvec;
  int   nerr;

  ram_loader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  ram_loader #(.DEPTH(16), .ADDR_W(4), .DATA_W(8)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: registered read, dout held while disabled, cleared by reset.
  logic [7:0] ram_mem [16];
  always @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < 16; i++) ram_mem[i] <= 8'h00;
      bus.ram_dout <= 8'h00;
    end else if (bus.ram_en) begin
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
      else            bus.ram_dout <= ram_mem[bus.ram_addr];
    end
  end

  logic [7:0]  ref_mem [16];
  logic [11:0] exp_wr [$];
  logic [7:0]  exp_out [$];
  int          exp_done [$];

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    logic [11:0] w;
    if (bus.ram_en && bus.ram_we) begin
      if (exp_wr.size() == 0) check("unexpected_write", 1, 0);
      else begin
        w = exp_wr.pop_front();
        check("wr_addr", 32'(bus.ram_addr), 32'(w[11:8]));
        check("wr_data", 32'(bus.ram_din), 32'(w[7:0]));
      end
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_out.size() == 0) check("unexpected_out", 1, 0);
      else check("out_data", 32'(bus.out_data), 32'(exp_out.pop_front()));
    end
    if (bus.done) begin
      if (exp_done.size() == 0) check("unexpected_done", 1, 0);
      else check("done_cycle", cyc, exp_done.pop_front());
    end
  end

  // mode: 0 = 0x10.. back-to-back, 1 = random data with valid toggling,
  // 2 = random data with random gaps, 3 = random data back-to-back
  task automatic do_load(input int mode, input bit both, input int abort_at);
    logic [7:0] img [16];
    int n, acc, k;
    bit v;
    for (int i = 0; i < 16; i++) img[i] = (mode == 0) ? 8'(8'h10 + i) : 8'($urandom);
    @(posedge clk); #1;
    bus.start_load = 1'b1;
    bus.start_dump = both;
    @(posedge clk); #1;
    bus.start_load = 1'b0;
    bus.start_dump = 1'b0;
    n = cyc;
    check("busy_after_start", 32'(bus.busy), 1);
    check("cpu_hold_after_start", 32'(bus.cpu_hold), 1);
    acc = 0;
    k = 0;
    while (acc < 16) begin
      if (acc == abort_at) begin
        bus.abort    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 0);
        check("abort_ram_en", 32'(bus.ram_en), 0);
        @(posedge clk); #1;
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        break;
      end
      v = (mode == 1) ? (k % 2 == 0) : (mode == 2) ? 1'($urandom_range(1)) : 1'b1;
      bus.in_valid = v;
      bus.in_data  = v ? img[acc] : 8'($urandom);
      if (v) begin
        exp_wr.push_back({4'(acc), img[acc]});
        ref_mem[acc] = img[acc];
        acc++;
      end
      k++;
      if (acc == 16) exp_done.push_back(n + k);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("busy_after_load", 32'(bus.busy), 0);
  endtask

  // stall_mode: 0 = ready always, 1 = 3-cycle stall on word 7, 2 = random stalls
  task automatic do_dump(input int stall_mode);
    int s [16];
    int total, n, w, left, t;
    total = 0;
    for (int i = 0; i < 16; i++) begin
      s[i] = (stall_mode == 2) ? int'($urandom_range(2)) :
             (stall_mode == 1 && i == 7) ? 3 : 0;
      total += 2 + s[i];
    end
    @(posedge clk); #1;
    bus.start_dump = 1'b1;
    @(posedge clk); #1;
    bus.start_dump = 1'b0;
    n = cyc;
    for (int i = 0; i < 16; i++) exp_out.push_back(ref_mem[i]);
    exp_done.push_back(n + total);
    w = 0;
    left = s[0];
    t = 0;
    while (w < 16 && t < 400) begin
      if (bus.out_valid) begin
        if (left > 0) begin
          bus.out_ready = 1'b0;
          check("stall_data", 32'(bus.out_data), 32'(ref_mem[w]));
          check("stall_ram_en", 32'(bus.ram_en), 0);
          left--;
        end else begin
          bus.out_ready = 1'b1;
          w++;
          if (w < 16) left = s[w];
        end
      end else begin
        bus.out_ready = 1'($urandom_range(1));
      end
      @(posedge clk); #1;
      t++;
    end
    bus.out_ready = 1'b0;
    if (w < 16) check("dump_timeout", 32'(w), 16);
    check("busy_after_dump", 32'(bus.busy), 0);
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    cyc = 0;
    areset = 1'b1;
    bus.start_load = 1'b0;
    bus.start_dump = 1'b0;
    bus.abort      = 1'b0;
    bus.in_data    = 8'h00;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    #2;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_cpu_hold", 32'(bus.cpu_hold), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_ram_en", 32'(bus.ram_en), 0);
    check("rst_ram_we", 32'(bus.ram_we), 0);
    check("rst_ram_addr", 32'(bus.ram_addr), 0);
    check("rst_ram_din", 32'(bus.ram_din), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;

    do_load(0, 1'b0, -1);
    check("ram5", 32'(ram_mem[5]), 32'h15);
    do_dump(0);
    do_dump(1);
    do_load(1, 1'b0, -1);
    do_dump(2);
    do_load(3, 1'b1, 4);
    do_dump(0);

    // abort in IDLE blocks a start in the same cycle
    @(posedge clk); #1;
    bus.abort = 1'b1;
    bus.start_load = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    bus.start_load = 1'b0;
    check("abort_blocks_start", 32'(bus.busy), 0);

    for (int r = 0; r < 4; r++) begin
      do_load(int'($urandom_range(3)), 1'($urandom_range(1)),
              ($urandom_range(3) == 0) ? int'($urandom_range(15)) : -1);
      do_dump(2);
    end

    // asynchronous reset while a word is presented
    @(posedge clk); #1;
    bus.start_dump = 1'b1;
    @(posedge clk); #1;
    bus.start_dump = 1'b0;
    for (int t = 0; t < 10 && !bus.out_valid; t++) begin
      @(posedge clk); #1;
    end
    check("pre_reset_out_valid", 32'(bus.out_valid), 1);
    #1 areset = 1'b1;
    #1;
    check("areset_out_valid", 32'(bus.out_valid), 0);
    check("areset_busy", 32'(bus.busy), 0);
    check("areset_ram_en", 32'(bus.ram_en), 0);
    check("areset_out_data", 32'(bus.out_data), 0);
    exp_out.delete();
    exp_done.delete();
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    @(posedge clk); #1;
    check("areset_done", 32'(bus.done), 0);
    areset = 1'b0;
    do_dump(0);

    repeat (3) @(posedge clk);
    check("wr_queue_empty", 32'(exp_wr.size()), 0);
    check("out_queue_empty", 32'(exp_out.size()), 0);
    check("done_queue_empty", 32'(exp_done.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
